// File: rtl/column_reducer.sv
// Folds one framed burst of ALU result beats into a SUM, MIN, MAX or COUNT-nonzero aggregate.
// Result appears 1 cycle after the last beat and is held via res_valid/res_ready until taken.
module column_reducer #(
  parameter int NUM = 31,
  parameter int CNT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               valid,
  input  logic [NUM:0]       in_data,
  input  logic               last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NUM+CNT+2:0] res_data,
  output logic [CNT:0]       res_count,
  output logic               res_sat,
  output logic               busy,
  output logic               drop_err
);

  localparam int AW = NUM + CNT + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_MIN = 2'd1;
  localparam logic [1:0] OP_MAX = 2'd2;
  localparam logic [1:0] OP_CNT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CNT:0]  cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          drop_q, drop_d;

  logic          start_acc;
  logic          beat_acc;
  logic          beat_drop;
  logic [1:0]    base_op;
  logic [AW-1:0] base_acc;
  logic [CNT:0]  base_cnt;
  logic          base_sat;
  logic          first_beat;
  logic [AW-1:0] beat_ext;

  // A start cycle folds its coincident beat onto fresh burst state, not the old one.
  always_comb begin
    start_acc  = enable & start & (state_q != S_HOLD);
    beat_acc   = enable & valid & (start_acc | (state_q == S_ACCUM));
    beat_drop  = enable & valid & ~beat_acc;
    base_op    = start_acc ? op : op_q;
    base_acc   = start_acc ? '0 : acc_q;
    base_cnt   = start_acc ? '0 : cnt_q;
    base_sat   = start_acc ? 1'b0 : sat_q;
    first_beat = (base_cnt == '0);
    beat_ext   = {{(AW-NUM-1){in_data[NUM]}}, in_data};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    drop_d  = drop_q;

    if (start_acc) begin
      state_d = S_ACCUM;
      op_d    = op;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end

    if (beat_acc) begin
      case (base_op)
        OP_SUM: acc_d = base_acc + beat_ext;
        OP_MIN: acc_d = (first_beat || ($signed(beat_ext) < $signed(base_acc))) ? beat_ext : base_acc;
        OP_MAX: acc_d = (first_beat || ($signed(beat_ext) > $signed(base_acc))) ? beat_ext : base_acc;
        OP_CNT: acc_d = base_acc + {{(AW-1){1'b0}}, |in_data};
        default: acc_d = base_acc;
      endcase
      // The counter sticks at all-ones; the aggregate keeps folding regardless.
      if (&base_cnt) begin
        cnt_d = base_cnt;
        sat_d = 1'b1;
      end else begin
        cnt_d = base_cnt + (CNT+1)'(1);
        sat_d = base_sat;
      end
      if (last) state_d = S_HOLD;
    end

    if (beat_drop) drop_d = 1'b1;

    if ((state_q == S_HOLD) && res_ready) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_SUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

  assign res_valid = (state_q == S_HOLD);
  assign res_data  = acc_q;
  assign res_count = cnt_q;
  assign res_sat   = sat_q;
  assign busy      = (state_q != S_IDLE);
  assign drop_err  = drop_q;

endmodule
